cla8_mp_addsub_seq: RTL
=======================

Name: cla8_mp_addsub_seq

Overview:
Sequencer that performs multi-precision add/subtract on BYTES-byte operands by time-multiplexing a single 8-bit carry-lookahead adder (cla8_adder), least-significant byte first. The carry between slices is held in a register. It uses a valid/ready handshake on both input and output, and is the arithmetic back-end for wide accumulate and compare paths in the lab datapath.

Parameters:
- BYTES, 4, operand width in bytes (W = 8*BYTES); legal range 2..16.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand request valid.
- in_ready, output, 1, high only in IDLE.
- a, input, W, operand A.
- b, input, W, operand B.
- sub, input, 1, 0 = A+B+cin; 1 = A−B−cin (cin acts as borrow-in).
- cin, input, 1, carry-in (add) or borrow-in (sub).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- sum, output, W, result.
- cout, output, 1, raw carry out of MSB. For sub, 1 = no borrow.
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset:
  - Synchronous, active-high. One clock; reset is synchronous and active-high.
  - On a clock edge with rst=1: state←IDLE, byte counter←0, carry reg←0, sum←0, cout←0, ovf←0, out_valid←0.
  - rst overrides any in-flight operation. Partial results are discarded and no out_valid is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b (inverted if sub=1), and sub. Set carry reg ← sub ? ~cin : cin, counter←0, and go to RUN.
  - RUN: each cycle drives the cla8_adder with byte[counter] of latched A, byte[counter] of latched B', and the carry reg.
    - sum byte[counter] ← adder sum; carry reg ← adder cout; counter++.
    - When counter==BYTES−1, also capture cout and ovf and go to DONE.
  - DONE: out_valid=1, and sum/cout/ovf held stable. On out_ready=1 go to IDLE.
- Latency and throughput:
  - Handshake accepted at edge T; RUN occupies edges T+1..T+BYTES; out_valid is high from just after edge T+BYTES.
  - Minimum issue interval is BYTES+2 cycles. No overlap: in_ready=0 in RUN and DONE, and in_valid is ignored there.
- Output timing:
  - in_ready and out_valid are decoded from registered state only. No combinational path from in_valid or out_ready.
  - sum is cleared to 0 on acceptance. Intermediate bytes are visible during RUN but carry no meaning while out_valid=0.
- Arithmetic:
  - ovf = carry into bit W−1 XOR cout. Carry into bit W−1 = A'[W−1] ^ B'[W−1] ^ sum[W−1], using the last-slice operands.
  - Wrap-around is modulo 2^W, with no saturation.
- Operand stability: the latched a/b/sub/cin are used, so the input buses may change freely after acceptance.
- Simultaneous events:
  - out_ready in DONE returns to IDLE. in_ready rises the following cycle, not the same cycle.
  - rst together with in_valid: reset wins and nothing is accepted.
- Counter: width $clog2(BYTES). It never exceeds BYTES−1, and wraps to 0 only via acceptance or rst.

Test Plan:
- BYTES=4, sub=0, cin=0, a=0x000000FF, b=0x00000001 → sum=0x00000100, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Add a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0. Separately, a=0x7FFFFFFF, b=1 → sum=0x80000000, cout=0, ovf=1.
- Sub, cin=0:
  - a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
  - a=0x80000000, b=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
  - Sub with cin=1: a=0x00000010, b=0x00000001 → sum=0x0000000E, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands meanwhile → out_valid, sum, cout and ovf stay stable, in_ready stays 0, and the pulsed request is not accepted. After out_ready=1, the next request is accepted with in_ready rising one cycle later.
- Reset mid-op: assert rst for 1 cycle after 2 RUN cycles → next cycle IDLE, in_ready=1, out_valid=0, sum=0. A following add 0x12345678+0x11111111 then yields 0x23456789, cout=0.
- Random soak: 10k random a/b/sub/cin with random out_ready stalls, compared against a reference model of {cout,sum} and ovf. Each accepted request must produce exactly one out_valid transfer.

Source files
------------

// File: rtl/cla8_mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one 8-bit carry-lookahead slice is reused
// least-significant byte first, with the inter-slice carry held in a register.

module cla8_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g, p;
  logic [8:0] c;

  // Returns carries into bits 1..4 of a 4-bit group, all flattened from ci.
  function automatic logic [3:0] cla4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
    logic [3:0] r;
    r[0] = gi[0] | (pi[0] & ci);
    r[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    r[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    r[3] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
         | (pi[3] & pi[2] & pi[1] & pi[0] & ci);
    return r;
  endfunction

  always_comb begin
    g      = a & b;
    p      = a ^ b;
    c      = '0;
    c[0]   = cin;
    c[4:1] = cla4(g[3:0], p[3:0], cin);
    c[8:5] = cla4(g[7:4], p[7:4], c[4]);
    sum    = p ^ c[7:0];
    cout   = c[8];
  end
endmodule

module cla8_mp_addsub_seq #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] a,
  input  logic [8*BYTES-1:0] b,
  input  logic               sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] sum,
  output logic               cout,
  output logic               ovf
);
  localparam int W  = 8 * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [W-1:0]  a_q, b_q;
  logic [7:0]    a_byte, b_byte, s_byte;
  logic          s_cout;

  assign a_byte = a_q[8*cnt +: 8];
  assign b_byte = b_q[8*cnt +: 8];

  cla8_adder u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (s_byte),
    .cout (s_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted once here.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            cnt   <= '0;
            sum   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[8*cnt +: 8] <= s_byte;
          carry           <= s_cout;
          if (cnt == LAST) begin
            cout  <= s_cout;
            ovf   <= a_byte[7] ^ b_byte[7] ^ s_byte[7] ^ s_cout;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
